// File: rtl/pixel_reorder_buffer_if.sv
// AXI4-Stream style pixel bus: the master drives data and framing flags, the slave returns tready.
interface pixel_reorder_buffer_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_reorder_buffer.sv
// In-order merge of N interleaved ray-tracing cores onto one raster-ordered AXI4-Stream output.
// Optional macro PIXEL_REORDER_STATS_EN adds saturating stall/starve cycle counters.
module pixel_reorder_buffer #(
  parameter int NUM_CORES = 4,
  parameter int COLOR_W   = 8,
  parameter int LINE_W    = 640,
  parameter int FRAME_H   = 480
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_CORES*3*COLOR_W-1:0]   in_pixel_i,
  input  logic [NUM_CORES-1:0]             in_valid_i,
  output logic [NUM_CORES-1:0]             in_ready_o,
  input  logic [$clog2(NUM_CORES+1)-1:0]   active_cores_i,
  pixel_reorder_buffer_if.master           m_axis
`ifdef PIXEL_REORDER_STATS_EN
  ,
  output logic [31:0]                      stall_cycles_o,
  output logic [31:0]                      starve_cycles_o
`endif
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int ACT_W = $clog2(NUM_CORES + 1);
  localparam int CUR_W = $clog2(NUM_CORES);
  localparam int X_W   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int Y_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_EOF} state_t;

  state_t                 state_q;
  logic [PIX_W-1:0]       slotData_q [NUM_CORES];
  logic [NUM_CORES-1:0]   slotValid_q;
  logic [NUM_CORES-1:0]   slotValid_d;
  logic [CUR_W-1:0]       cur_q;
  logic [ACT_W-1:0]       nAct_q;
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [PIX_W-1:0]       outData_q;
  logic                   outValid_q;
  logic                   outUser_q;
  logic                   outLast_q;

  logic [ACT_W-1:0]       reqAct;
  logic [NUM_CORES-1:0]   accept;
  logic [NUM_CORES-1:0]   curMask;
  logic [NUM_CORES-1:0]   drainMask;
  logic                   outHandshake;
  logic                   outFree;
  logic                   load;
  logic                   lastX;
  logic                   lastY;
  logic                   curWrap;

  // A request of 0 cores still means one core; anything beyond the hardware is clamped.
  always_comb begin
    reqAct = active_cores_i;
    if (active_cores_i == '0)
      reqAct = ACT_W'(1);
    else if (active_cores_i > ACT_W'(NUM_CORES))
      reqAct = ACT_W'(NUM_CORES);
  end

  always_comb begin
    in_ready_o = '0;
    for (int k = 0; k < NUM_CORES; k++)
      in_ready_o[k] = (state_q == ST_RUN) && !slotValid_q[k] && (ACT_W'(k) < nAct_q);
  end

  assign accept       = in_valid_i & in_ready_o;
  assign outHandshake = outValid_q && m_axis.tready;
  assign outFree      = !outValid_q || m_axis.tready;
  assign load         = (state_q == ST_RUN) && outFree && slotValid_q[cur_q];
  assign curMask      = NUM_CORES'(1) << cur_q;
  assign drainMask    = load ? curMask : '0;
  assign lastX        = (x_q == X_W'(LINE_W - 1));
  assign lastY        = (y_q == Y_W'(FRAME_H - 1));
  assign curWrap      = (ACT_W'(cur_q) == nAct_q - ACT_W'(1));

  // An accept and a drain never hit the same slot in one cycle, so set/clear cannot collide.
  always_comb begin
    slotValid_d = (slotValid_q | accept) & ~drainMask;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_CORES; k++)
        slotData_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++)
        if (accept[k])
          slotData_q[k] <= in_pixel_i[k*PIX_W +: PIX_W];
    end
  end

  // Frame FSM plus the output register; the raster position is stamped when a pixel is loaded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_CFG;
      slotValid_q <= '0;
      cur_q       <= '0;
      nAct_q      <= ACT_W'(1);
      x_q         <= '0;
      y_q         <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outUser_q   <= 1'b0;
      outLast_q   <= 1'b0;
    end else begin
      slotValid_q <= slotValid_d;

      case (state_q)
        ST_CFG: begin
          if (slotValid_q == '0)
            nAct_q <= reqAct;
          cur_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (load) begin
            cur_q <= curWrap ? '0 : cur_q + CUR_W'(1);
            if (lastX) begin
              x_q <= '0;
              y_q <= lastY ? '0 : y_q + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
            if (lastX && lastY)
              state_q <= ST_EOF;
          end
        end
        ST_EOF: begin
          if (outHandshake)
            state_q <= ST_CFG;
        end
        default: state_q <= ST_CFG;
      endcase

      if (load) begin
        outValid_q <= 1'b1;
        outData_q  <= slotData_q[cur_q];
        outUser_q  <= (x_q == '0) && (y_q == '0);
        outLast_q  <= lastX;
      end else if (outHandshake) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = outData_q;
  assign m_axis.tvalid = outValid_q;
  assign m_axis.tuser  = outUser_q;
  assign m_axis.tlast  = outLast_q;

`ifdef PIXEL_REORDER_STATS_EN
  logic [31:0] stallCnt_q;
  logic [31:0] starveCnt_q;
  logic        starveNow;

  // Starving: output could take a pixel, the in-order slot is empty, yet another core is waiting.
  assign starveNow = outFree && !slotValid_q[cur_q] && (|(slotValid_q & ~curMask));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stallCnt_q  <= '0;
      starveCnt_q <= '0;
    end else begin
      if (outValid_q && !m_axis.tready && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + 32'd1;
      if (starveNow && (starveCnt_q != '1))
        starveCnt_q <= starveCnt_q + 32'd1;
    end
  end

  assign stall_cycles_o  = stallCnt_q;
  assign starve_cycles_o = starveCnt_q;
`endif

endmodule
